// File: rtl/mc_ctrl_112.sv
// mc_ctrl_112: multi-cycle MIPS control unit (IF/ID/EX/MEM/WB) driving ALUctr, datapath muxes and write enables.
// Optional macro MC_ILLEGAL_HALT_EN: illegal op/funct parks the FSM in HALT until reset; otherwise it is a NOP.
module mc_ctrl_112 #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            Zero,
    input  logic            Overflow,
    output logic            PCWr,
    output logic            IRWr,
    output logic            RegWr,
    output logic            MemWr,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            ExtOp,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSrc,
    output logic [2:0]      ALUctr,
    output logic [ST_W-1:0] state,
    output logic            halted
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_R    = 4'd7,
        S_WB_I    = 4'd8,
        S_WB_LD   = 4'd9,
        S_BR      = 4'd10,
        S_JMP     = 4'd11,
        S_HALT    = 4'd12
    } state_t;

`ifdef MC_ILLEGAL_HALT_EN
    localparam state_t ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t ILLEGAL_NEXT = S_IF;
`endif

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ext_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctr;
    } ctl_t;

    state_t cur_state;
    state_t nxt_state;
    logic   ov_flag;
    logic   nxt_ov;
    ctl_t   ctl;

    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'b100001, 6'b100000, 6'b100101, 6'b100011,
            6'b100010, 6'b101011, 6'b101010: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            6'b100001: a = 3'b000;
            6'b100000: a = 3'b001;
            6'b100101: a = 3'b010;
            6'b100011: a = 3'b100;
            6'b100010: a = 3'b101;
            6'b101011: a = 3'b110;
            6'b101010: a = 3'b111;
            default:   a = 3'b000;
        endcase
        return a;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [5:0] o, input logic [5:0] f);
        state_t n;
        n = S_IF;
        case (s)
            S_IF: n = S_ID;
            S_ID: begin
                case (o)
                    OP_RTYPE:        n = funct_legal(f) ? S_EX_R : ILLEGAL_NEXT;
                    OP_ORI, OP_ADDIU: n = S_EX_I;
                    OP_LW, OP_SW:    n = S_MEM_ADR;
                    OP_BEQ:          n = S_BR;
                    OP_J:            n = S_JMP;
                    default:         n = ILLEGAL_NEXT;
                endcase
            end
            S_EX_R:    n = S_WB_R;
            S_EX_I:    n = S_WB_I;
            S_MEM_ADR: n = (o == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  n = S_WB_LD;
            S_HALT:    n = S_HALT;
            default:   n = S_IF;
        endcase
        return n;
    endfunction

    // Control word for a state; op/funct are already held by IR whenever they matter.
    function automatic ctl_t decode(input state_t s, input logic [5:0] o, input logic [5:0] f,
                                    input logic ov);
        ctl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.ir_wr     = 1'b1;
                c.pc_wr     = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_ID: begin
                c.alu_src_b = 2'b11;
                c.ext_op    = 1'b1;
            end
            S_EX_R: begin
                c.alu_src_a = 1'b1;
                c.alu_ctr   = r_alu(f);
            end
            S_EX_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.ext_op    = (o != OP_ORI);
                c.alu_ctr   = (o == OP_ORI) ? 3'b010 : 3'b000;
            end
            S_MEM_ADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.ext_op    = 1'b1;
            end
            S_MEM_WR: c.mem_wr = 1'b1;
            S_WB_R: begin
                c.reg_dst = 1'b1;
                c.reg_wr  = ~ov;
            end
            S_WB_I:  c.reg_wr = ~ov;
            S_WB_LD: begin
                c.mem_to_reg = 1'b1;
                c.reg_wr     = 1'b1;
            end
            S_BR: begin
                c.alu_src_a = 1'b1;
                c.alu_ctr   = 3'b100;
                c.pc_src    = 2'b01;
            end
            S_JMP: begin
                c.pc_src = 2'b10;
                c.pc_wr  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt_state = next_of(cur_state, op, funct);
        nxt_ov    = ov_flag;
        if (cur_state == S_IF)
            nxt_ov = 1'b0;
        else if (cur_state == S_EX_R || cur_state == S_EX_I)
            nxt_ov = Overflow;
    end

`ifdef MC_ILLEGAL_HALT_EN
    logic halted_q;
`endif

    // Outputs are registered by decoding the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IF;
            ov_flag   <= 1'b0;
            ctl       <= decode(S_IF, 6'd0, 6'd0, 1'b0);
`ifdef MC_ILLEGAL_HALT_EN
            halted_q  <= 1'b0;
`endif
        end else begin
            cur_state <= nxt_state;
            ov_flag   <= nxt_ov;
            ctl       <= decode(nxt_state, op, funct, nxt_ov);
`ifdef MC_ILLEGAL_HALT_EN
            halted_q  <= (nxt_state == S_HALT);
`endif
        end
    end

`ifdef MC_ILLEGAL_HALT_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    // Write enables are masked while reset is held; only the branch PC write follows Zero live.
    assign PCWr     = ~rst & (ctl.pc_wr | ((cur_state == S_BR) & Zero));
    assign IRWr     = ~rst & ctl.ir_wr;
    assign RegWr    = ~rst & ctl.reg_wr;
    assign MemWr    = ~rst & ctl.mem_wr;
    assign RegDst   = ctl.reg_dst;
    assign MemtoReg = ctl.mem_to_reg;
    assign ExtOp    = ctl.ext_op;
    assign ALUSrcA  = ctl.alu_src_a;
    assign ALUSrcB  = ctl.alu_src_b;
    assign PCSrc    = ctl.pc_src;
    assign ALUctr   = ctl.alu_ctr;
    assign state    = ST_W'(cur_state);

endmodule

// File: tb/tb_mc_ctrl_112.sv
// tb_mc_ctrl_112: scoreboard bench for mc_ctrl_112; per-instruction expected cycle traces come from an instruction-level table.
// Honours MC_ILLEGAL_HALT_EN the same way the design does.
module tb_mc_ctrl_112;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       Zero = 1'b0;
    logic       Overflow = 1'b0;
    logic       PCWr, IRWr, RegWr, MemWr, RegDst, MemtoReg, ExtOp, ALUSrcA, halted;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUctr;
    logic [3:0] state;

    mc_ctrl_112 #(.ST_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .Zero(Zero), .Overflow(Overflow),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUctr(ALUctr), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwr, irwr, regwr, memwr, regdst, memtoreg, extop, asrca;
        logic [1:0] asrcb, pcsrc;
        logic [2:0] actr;
        logic       halted;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
    logic [5:0] legal_functs [7] = '{6'b100001, 6'b100000, 6'b100101, 6'b100011,
                                      6'b100010, 6'b101011, 6'b101010};
    logic [2:0] funct_alu    [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

    function automatic int funct_idx(input logic [5:0] f);
        for (int i = 0; i < 7; i++)
            if (legal_functs[i] == f) return i;
        return -1;
    endfunction

    function automatic bit op_known(input logic [5:0] o);
        return o == OP_R || o == OP_ORI || o == OP_ADDIU || o == OP_LW ||
               o == OP_SW || o == OP_BEQ || o == OP_J;
    endfunction

    function automatic exp_t rec(input int st);
        exp_t e;
        e = '0;
        e.st = 4'(st);
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.st = state;       a.pcwr = PCWr;       a.irwr = IRWr;     a.regwr = RegWr;
        a.memwr = MemWr;    a.regdst = RegDst;   a.memtoreg = MemtoReg;
        a.extop = ExtOp;    a.asrca = ALUSrcA;   a.asrcb = ALUSrcB; a.pcsrc = PCSrc;
        a.actr = ALUctr;    a.halted = halted;
        return a;
    endfunction

    task automatic checkOutput(input string name, input exp_t want);
        exp_t got;
        got = actual();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                     name, got.st, got, want.st, want);
        end
    endtask

    // While reset is held: state IF, all write enables low, not halted.
    task automatic checkReset(input string name);
        logic [8:0] got;
        got = {state, PCWr, IRWr, RegWr, MemWr, halted};
        n_cmp++;
        if (got !== 9'd0) begin
            n_bad++;
            $display("[TB] FAIL %s: got {state,PCWr,IRWr,RegWr,MemWr,halted}=%b, expected 0", name, got);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL sb_empty: DUT in state %0d with nothing expected", state);
            end else begin
                checkOutput($sformatf("cycle@%0t", $time), sb.pop_front());
            end
        end
    end

    task automatic doReset();
        rst = 1'b1;
        #1;
        checkReset("rst_async");
        @(posedge clk);
        #1;
        checkReset("rst_hold");
        rst = 1'b0;
    endtask

    // Issue one instruction at the start of its IF cycle; returns at the start of the following IF.
    task automatic applyStimulus(input logic [5:0] op_i, input logic [5:0] funct_i,
                                 input logic zero_i, input logic ov_i, output bit went_halt);
        exp_t e;
        int   n;
        int   fi;
        went_halt = 1'b0;
        op = op_i; funct = funct_i; Zero = zero_i; Overflow = ov_i;
        fi = funct_idx(funct_i);
        e = rec(0); e.pcwr = 1; e.irwr = 1; e.asrcb = 2'b01; sb.push_back(e);
        e = rec(1); e.asrcb = 2'b11; e.extop = 1;           sb.push_back(e);
        n = 2;
        if (op_i == OP_R && fi >= 0) begin
            e = rec(2); e.asrca = 1; e.actr = funct_alu[fi]; sb.push_back(e);
            e = rec(7); e.regdst = 1; e.regwr = !ov_i;        sb.push_back(e);
            n = 4;
        end else if (op_i == OP_ORI || op_i == OP_ADDIU) begin
            e = rec(3); e.asrca = 1; e.asrcb = 2'b10;
            e.extop = (op_i == OP_ADDIU); e.actr = (op_i == OP_ORI) ? 3'b010 : 3'b000;
            sb.push_back(e);
            e = rec(8); e.regwr = !ov_i; sb.push_back(e);
            n = 4;
        end else if (op_i == OP_LW || op_i == OP_SW) begin
            e = rec(4); e.asrca = 1; e.asrcb = 2'b10; e.extop = 1; sb.push_back(e);
            if (op_i == OP_LW) begin
                sb.push_back(rec(5));
                e = rec(9); e.memtoreg = 1; e.regwr = 1; sb.push_back(e);
                n = 5;
            end else begin
                e = rec(6); e.memwr = 1; sb.push_back(e);
                n = 4;
            end
        end else if (op_i == OP_BEQ) begin
            e = rec(10); e.asrca = 1; e.actr = 3'b100; e.pcsrc = 2'b01; e.pcwr = zero_i;
            sb.push_back(e);
            n = 3;
        end else if (op_i == OP_J) begin
            e = rec(11); e.pcsrc = 2'b10; e.pcwr = 1; sb.push_back(e);
            n = 3;
        end else begin
`ifdef MC_ILLEGAL_HALT_EN
            repeat (3) begin
                e = rec(12); e.halted = 1; sb.push_back(e);
            end
            n = 5;
            went_halt = 1'b1;
`endif
        end
        repeat (n) @(posedge clk);
        #1;
        if (went_halt) doReset();
    endtask

    // lw abandoned by a reset pulse in the middle of MEM_RD.
    task automatic resetMidLoad();
        exp_t e;
        op = OP_LW; funct = 6'($urandom); Zero = 1'b0; Overflow = 1'b0;
        e = rec(0); e.pcwr = 1; e.irwr = 1; e.asrcb = 2'b01; sb.push_back(e);
        e = rec(1); e.asrcb = 2'b11; e.extop = 1;           sb.push_back(e);
        e = rec(4); e.asrca = 1; e.asrcb = 2'b10; e.extop = 1; sb.push_back(e);
        sb.push_back(rec(5));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        doReset();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         h;
        int         cls;
        logic [5:0] o, f;
        #2;
        doReset();
        mon_en = 1'b1;

        applyStimulus(OP_R, 6'b100001, 1'b0, 1'b0, h);
        applyStimulus(OP_R, 6'b100010, 1'b0, 1'b1, h);
        applyStimulus(OP_LW, 6'd5, 1'b0, 1'b0, h);
        applyStimulus(OP_SW, 6'd9, 1'b1, 1'b0, h);
        applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b0, h);
        applyStimulus(OP_BEQ, 6'd0, 1'b0, 1'b0, h);
        applyStimulus(OP_ORI, 6'd3, 1'b0, 1'b0, h);
        applyStimulus(OP_J, 6'd1, 1'b0, 1'b0, h);
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b0, h);
        resetMidLoad();
        applyStimulus(OP_R, 6'b000111, 1'b0, 1'b0, h);

        for (int k = 0; k < 80; k++) begin
            cls = $urandom_range(0, 9);
            f   = 6'($urandom);
            case (cls)
                0, 1, 2: begin o = OP_R; f = legal_functs[$urandom_range(0, 6)]; end
                3: o = OP_ORI;
                4: o = OP_ADDIU;
                5: o = OP_LW;
                6: o = OP_SW;
                7: o = OP_BEQ;
                8: o = OP_J;
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        do o = 6'($urandom); while (op_known(o));
                    end else begin
                        o = OP_R;
                        do f = 6'($urandom); while (funct_idx(f) >= 0);
                    end
                end
            endcase
            applyStimulus(o, f, 1'($urandom), 1'($urandom), h);
            if (k == 40) resetMidLoad();
        end

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL sb_drain: %0d expected cycles never observed, required 0", sb.size());
        end
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
